// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - memory-stage request and data-memory port bundle for store_buffer
interface store_buffer_if #(
    parameter int WAM = 17,
    parameter int WD  = 32
);
    logic [WAM:0] aluresultM;
    logic [WD-1:0] writedataM;
    logic [2:0]    memctrlM;
    logic          memwriteM;
    logic          memreadM;
    logic          flushM;
    logic          stallM;
    logic [WD-1:0] readdataM;
    logic [WAM:0]  mem_addr;
    logic [WD-1:0] mem_wdata;
    logic [2:0]    mem_ctrl;
    logic          mem_we;
    logic          mem_re;
    logic [WD-1:0] mem_rdata;

    modport slave (
        input  aluresultM, writedataM, memctrlM, memwriteM, memreadM, flushM, mem_rdata,
        output stallM, readdataM, mem_addr, mem_wdata, mem_ctrl, mem_we, mem_re
    );

    modport master (
        output aluresultM, writedataM, memctrlM, memwriteM, memreadM, flushM, mem_rdata,
        input  stallM, readdataM, mem_addr, mem_wdata, mem_ctrl, mem_we, mem_re
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store FIFO sharing one data-memory port with loads; STORE_FWD_EN enables word store-to-load forwarding
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int WAM   = 17,
    parameter int WD    = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  head_q, tail_q;
    logic [PW:0]    count_q, count_d;
    logic [WAM:0]   addr_q [DEPTH];
    logic [WD-1:0]  data_q [DEPTH];
    logic [2:0]     ctrl_q [DEPTH];

    logic           empty, full;
    logic           hazard;
    logic           fwd_ok;
    logic [WD-1:0]  fwd_data;
    logic           enq, drain, port_used, flushing;
    logic [PW-1:0]  off;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(DEPTH));

    // An entry is live when its distance from head is below count.
    always_comb begin
        hazard = 1'b0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head_q;
            if ({1'b0, off} < count_q && addr_q[i][WAM:2] == bus.aluresultM[WAM:2])
                hazard = 1'b1;
        end
    end

`ifdef STORE_FWD_EN
    logic           fwd_found;
    logic [PW-1:0]  fwd_idx, idx;

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        fwd_found = 1'b0;
        fwd_idx   = head_q;
        idx       = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((PW+1)'(k) < count_q && addr_q[idx][WAM:2] == bus.aluresultM[WAM:2]) begin
                fwd_found = 1'b1;
                fwd_idx   = idx;
            end
        end
        fwd_ok   = fwd_found && ctrl_q[fwd_idx] != 3'b010 && bus.memctrlM != 3'b011;
        fwd_data = data_q[fwd_idx];
    end
`else
    assign fwd_ok   = 1'b0;
    assign fwd_data = '0;
`endif

    assign flushing = (state_q == FLUSH) || (bus.flushM && !empty);

    always_comb begin
        state_d       = state_q;
        enq           = 1'b0;
        drain         = 1'b0;
        port_used     = 1'b0;
        bus.stallM    = 1'b0;
        bus.readdataM = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_ctrl  = '0;

        if (flushing) begin
            bus.stallM = 1'b1;
        end else if (bus.memwriteM) begin
            // A simultaneous read request is treated as a plain store.
            if (full)
                bus.stallM = 1'b1;
            else
                enq = 1'b1;
        end else if (bus.memreadM) begin
            if (hazard && !fwd_ok) begin
                bus.stallM = 1'b1;
            end else if (hazard) begin
                bus.readdataM = fwd_data;
            end else begin
                port_used     = 1'b1;
                bus.mem_re    = 1'b1;
                bus.mem_addr  = bus.aluresultM;
                bus.mem_ctrl  = bus.memctrlM;
                bus.readdataM = bus.mem_rdata;
            end
        end

        if (!empty && !port_used) begin
            drain         = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = addr_q[head_q];
            bus.mem_wdata = data_q[head_q];
            bus.mem_ctrl  = ctrl_q[head_q];
        end

        count_d = count_q + (PW+1)'(enq) - (PW+1)'(drain);

        // Leave FLUSH on the edge that retires the last entry.
        if (flushing)
            state_d = (count_d != '0) ? FLUSH : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (enq)
                tail_q <= tail_q + 1'b1;
            if (drain)
                head_q <= head_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= bus.aluresultM;
            data_q[tail_q] <= bus.writedataM;
            ctrl_q[tail_q] <= bus.memctrlM;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized and directed check of store_buffer against a queue-based model; honours STORE_FWD_EN
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if #(.WAM(17), .WD(32)) bus ();

    store_buffer #(.DEPTH(DEPTH), .WAM(17), .WD(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [17:0] addr;
        logic [31:0] data;
        logic [2:0]  ctrl;
    } st_t;

    st_t         sq[$];
    bit          flushing = 1'b0;
    logic [31:0] dut_mem [16];
    logic [31:0] ref_mem [16];
    int          vectors = 0;
    int          errors  = 0;

    always_comb bus.mem_rdata = dut_mem[bus.mem_addr[5:2]];

    always @(posedge clk) begin
        if (rst_n && bus.mem_we) begin
            if (bus.mem_ctrl == 3'b010)
                dut_mem[bus.mem_addr[5:2]][8*bus.mem_addr[1:0] +: 8] = bus.mem_wdata[7:0];
            else
                dut_mem[bus.mem_addr[5:2]] = bus.mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic ref_write(input st_t s);
        if (s.ctrl == 3'b010)
            ref_mem[s.addr[5:2]][8*s.addr[1:0] +: 8] = s.data[7:0];
        else
            ref_mem[s.addr[5:2]] = s.data;
    endtask

    // One pipeline cycle: drive, predict from the pending-store queue, compare, retire.
    task automatic cycle(input logic [17:0] a, input logic [31:0] d, input logic [2:0] c,
                         input logic we, input logic re, input logic fl);
        int          n, young;
        bit          enq, drain, port;
        logic        e_stall, e_we, e_re;
        logic [31:0] e_rd, e_wd;
        logic [17:0] e_addr;
        logic [2:0]  e_ctrl;
        bus.aluresultM = a;
        bus.writedataM = d;
        bus.memctrlM   = c;
        bus.memwriteM  = we;
        bus.memreadM   = re;
        bus.flushM     = fl;
        @(negedge clk);
        n = sq.size();
        enq = 0; drain = 0; port = 0;
        e_stall = 0; e_we = 0; e_re = 0; e_rd = 0; e_wd = 0; e_addr = 0; e_ctrl = 0;
        if (flushing || (fl && n > 0)) begin
            e_stall = 1;
        end else if (we) begin
            if (n == DEPTH) e_stall = 1;
            else enq = 1;
        end else if (re) begin
            young = -1;
            for (int i = 0; i < n; i++)
                if (sq[i].addr[17:2] == a[17:2]) young = i;
            if (young >= 0) begin
`ifdef STORE_FWD_EN
                if (sq[young].ctrl != 3'b010 && c != 3'b011) e_rd = sq[young].data;
                else e_stall = 1;
`else
                e_stall = 1;
`endif
            end else begin
                port = 1; e_re = 1; e_addr = a; e_ctrl = c; e_rd = ref_mem[a[5:2]];
            end
        end
        if (n > 0 && !port) begin
            drain = 1; e_we = 1;
            e_addr = sq[0].addr; e_wd = sq[0].data; e_ctrl = sq[0].ctrl;
        end
        chk("stallM", 32'(bus.stallM), 32'(e_stall));
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        chk("mem_re", 32'(bus.mem_re), 32'(e_re));
        chk("readdataM", bus.readdataM, e_rd);
        chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        chk("mem_wdata", bus.mem_wdata, e_wd);
        chk("mem_ctrl", 32'(bus.mem_ctrl), 32'(e_ctrl));
        @(posedge clk);
        flushing = flushing || (fl && n > 0);
        if (drain) begin
            ref_write(sq[0]);
            void'(sq.pop_front());
        end
        if (enq) sq.push_back('{a, d, c});
        if (sq.size() == 0) flushing = 0;
        #1;
    endtask

    task automatic idle();
        cycle(18'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    logic [17:0] last_addr;
    logic [17:0] ra;

    initial begin
        for (int i = 0; i < 16; i++) begin
            dut_mem[i] = $urandom;
            ref_mem[i] = dut_mem[i];
        end
        bus.aluresultM = '0; bus.writedataM = '0; bus.memctrlM = '0;
        bus.memwriteM = 0; bus.memreadM = 0; bus.flushM = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (5) idle();

        // Word store then idle: retires the following cycle.
        cycle(18'h100, 32'hDEADBEEF, 3'b110, 1'b1, 1'b0, 1'b0);
        idle();
        idle();

        // Byte store, then word load of the same word stalls until it drains.
        cycle(18'h103, 32'h00000055, 3'b010, 1'b1, 1'b0, 1'b0);
        cycle(18'h100, 32'h0, 3'b110, 1'b0, 1'b1, 1'b0);
        cycle(18'h100, 32'h0, 3'b110, 1'b0, 1'b1, 1'b0);

        // Word store, word load of same address next cycle (forwarded when enabled).
        cycle(18'h040, 32'h12345678, 3'b110, 1'b1, 1'b0, 1'b0);
        cycle(18'h040, 32'h0, 3'b110, 1'b0, 1'b1, 1'b0);
        idle();

        // Store held behind a non-conflicting load, then fence.
        cycle(18'h010, 32'hA5A5A5A5, 3'b110, 1'b1, 1'b0, 1'b0);
        cycle(18'h200, 32'h0, 3'b110, 1'b0, 1'b1, 1'b0);
        cycle(18'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
        idle();

        // Reset with a store pending: the store must never reach memory.
        cycle(18'h020, 32'hCAFEF00D, 3'b110, 1'b1, 1'b0, 1'b0);
        cycle(18'h300, 32'h0, 3'b110, 1'b0, 1'b1, 1'b0);
        bus.memreadM = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_stallM", 32'(bus.stallM), 32'd0);
        chk("rst_readdataM", bus.readdataM, 32'd0);
        sq.delete();
        flushing = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) idle();

        last_addr = 18'h0;
        for (int t = 0; t < 400; t++) begin
            logic       we, re, fl;
            logic [2:0] c;
            int         r;
            r  = $urandom_range(0, 99);
            we = (r < 40) || (r >= 95);
            re = (r >= 40 && r < 80) || (r >= 95);
            fl = ($urandom_range(0, 15) == 0);
            c  = ($urandom_range(0, 2) == 0) ? (we ? 3'b010 : 3'b011) : 3'b110;
            ra = ($urandom_range(0, 1) == 0) ? last_addr : 18'($urandom_range(0, 63));
            if (we) last_addr = ra;
            cycle(ra, $urandom, c, we, re, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store buffer between the memory-stage pipeline register and the byte-addressed data memory. Stores are queued in a small FIFO and retire to memory in cycles when no load uses the single memory port, so a load never waits behind a store. Loads whose word address matches a pending store stall until that store has drained. A flush request drains the whole buffer before the pipeline proceeds.

## Interface
- DEPTH, 4, number of buffered stores; power of two, ≥2
- WAM, 17, MSB index of the byte address (address is WAM+1 bits)
- WD, 32, data width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- aluresultM  in  WAM+1  byte address from memory stage
- writedataM  in  WD  store data
- memctrlM  in  3  3'b010 byte store, 3'b011 byte load, other values word access
- memwriteM  in  1  store request
- memreadM  in  1  load request
- flushM  in  1  drain request (fence)
- stallM  out  1  hold memory stage; request not consumed this cycle
- readdataM  out  WD  load data to writeback
- mem_addr  out  WAM+1  address to data memory
- mem_wdata  out  WD  write data to data memory
- mem_ctrl  out  3  memctrl to data memory
- mem_we  out  1  write enable to data memory
- mem_re  out  1  read enable to data memory
- mem_rdata  in  WD  combinational read data from data memory

## Operation
- Storage: DEPTH entries {addr, data, ctrl}; head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits; full = count==DEPTH, empty = count==0.
- Store: memwriteM & ~full → enqueue at tail on the clock edge, stallM=0. memwriteM & full → stallM=1, no enqueue, even if a drain occurs that cycle.
- Load hazard: any valid entry with addr[WAM:2]==aluresultM[WAM:2] (word granularity, all ctrl types) → stallM=1, mem_re=0.
- Load, no hazard: mem_re=1, mem_addr/mem_ctrl from aluresultM/memctrlM, readdataM=mem_rdata, stallM=0; no drain this cycle.
- Drain: ~empty and port not used by a non-stalled load → mem_we=1, mem_addr/mem_wdata/mem_ctrl from head entry; head pops on the edge. Hazard-stalled loads do not block draining.
- Simultaneous enqueue and drain: count unchanged, both pointers advance.
- memwriteM & memreadM together: illegal; the block treats the request as a store.
- FSM: RUN, FLUSH. RUN → FLUSH when flushM & ~empty. In FLUSH: stallM=1, loads and stores ignored, drain every cycle; FLUSH → RUN on the edge where count goes 1→0. flushM with empty buffer: stay in RUN, stallM=0.
- Idle outputs: mem_we=0, mem_re=0, readdataM=0, mem_addr/mem_wdata/mem_ctrl=0.

## Timing
- Reset (async assert, sync release): count=0, head=tail=0, state=RUN, stallM=0, mem_we=0, mem_re=0, readdataM=0; entry contents don't-care.
- Reset mid-operation discards all pending stores; they are never written.
- Load latency: 0 cycles; readdataM is combinational in the request cycle.
- Store into an empty buffer at edge N: mem_we=1 during cycle N+1, memory updated at edge N+1 unless a load takes the port.
- Hazard stall lasts until the matching entries retire; the load completes in the first cycle after the last matching entry pops.
- stallM is combinational from the current-cycle inputs and registered state.

## Configuration
- STORE_FWD_EN defined: on a hazard where the youngest matching entry is a word store and the load is a word load, readdataM = that entry's data, stallM=0, mem_re=0, and the drain proceeds normally. All other hazards stall.
- STORE_FWD_EN undefined: every hazard stalls as described in Operation.

## Test plan
- Reset then idle: stallM=0, mem_we=0, mem_re=0, readdataM=0 for 5 cycles.
- Store word 0xDEADBEEF @0x100 then idle: mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF in the next cycle, and count returns to 0.
- 5 back-to-back stores while loads from 0x200 block the port: the 5th store sees stallM=1 until the first pop, and drain order matches issue order.
- Byte store 0x55 @0x103 then word load @0x100: stallM=1 until the entry pops, then a load with mem_re=1 (also a stall with STORE_FWD_EN defined).
- With STORE_FWD_EN defined: word store 0x12345678 @0x40, then word load @0x40 next cycle: readdataM=0x12345678, stallM=0.
- 3 stores queued, then flushM=1: stallM=1 for 3 cycles, 3 mem_we pulses, return to RUN; asserting rst_n=0 in the second flush cycle leaves no further mem_we.
